// File: rtl/grid_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | grid_pkg : shared widths, FSM states and point record for grid gen   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package grid_pkg;

    // Point record is sized for the widest supported build; instances slice it.
    localparam int MAX_COORD_W = 16;
    localparam int MAX_IDX_W   = 8;

    function automatic int num_w(input int size_w, input int grid);
        return size_w + $clog2(2 * grid);
    endfunction

    function automatic int idx_w(input int grid);
        return $clog2(grid * grid);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        EMIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [MAX_COORD_W-1:0] x;
        logic [MAX_COORD_W-1:0] y;
        logic [MAX_IDX_W-1:0]   index;
        logic                   last;
        logic                   clip;
    } point_t;

endpackage
`default_nettype wire

// File: rtl/grid_center_gen_serial_const_div.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_const_div : restoring divider by a constant, 1 bit per cycle  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module serial_const_div #(
    parameter int NUM_W   = 13,
    parameter int DIVISOR = 6
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Load,
    input  logic [NUM_W-1:0] Numer,
    output logic             Busy,
    output logic             Done,
    output logic [NUM_W-1:0] Quotient
);
    localparam int REM_W = $clog2(DIVISOR) + 1;
    localparam int CNT_W = $clog2(NUM_W);
    localparam logic [REM_W-1:0] c_divisor = REM_W'(DIVISOR);
    localparam logic [CNT_W-1:0] c_last    = CNT_W'(NUM_W - 1);

    logic [REM_W-2:0] r_rem;
    logic [NUM_W-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [REM_W-1:0] w_trial;
    logic             w_ge;

    // r_q shifts numerator bits out of the top and quotient bits in at the bottom.
    assign w_trial = {r_rem, r_q[NUM_W-1]};
    assign w_ge    = (w_trial >= c_divisor);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_rem  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (Load) begin
                r_q    <= Numer;
                r_rem  <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_q   <= {r_q[NUM_W-2:0], w_ge};
                r_rem <= w_ge ? (REM_W-1)'(w_trial - c_divisor) : w_trial[REM_W-2:0];
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_cnt == c_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Quotient = r_q;

endmodule
`default_nettype wire

// File: rtl/grid_center_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | grid_center_gen : streams GRIDxGRID cube-face sample centres         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module grid_center_gen
    import grid_pkg::*;
#(
    parameter int GRID    = 3,
    parameter int COORD_W = 11,
    parameter int SIZE_W  = 10
) (
    input  logic                            Clk,
    input  logic                            Reset_n,
    input  logic                            Start,
    input  logic [COORD_W-1:0]              CubeX_Start,
    input  logic [COORD_W-1:0]              CubeY_Start,
    input  logic [SIZE_W-1:0]               N,
    output logic                            Busy,
    output logic                            Done,
    output logic                            Point_Valid,
    input  logic                            Point_Ready,
    output logic [COORD_W-1:0]              Point_X,
    output logic [COORD_W-1:0]              Point_Y,
    output logic [grid_pkg::idx_w(GRID)-1:0] Point_Index,
    output logic                            Point_Last,
    output logic                            Point_Clip
);
    localparam int NUM_W = num_w(SIZE_W, GRID);
    localparam int IDX_W = idx_w(GRID);
    localparam int K_W   = $clog2(GRID);
    localparam int CYC_W = $clog2(NUM_W + 1);
    localparam logic [K_W-1:0]   c_k_last   = K_W'(GRID - 1);
    localparam logic [CYC_W-1:0] c_cyc_last = CYC_W'(NUM_W);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(GRID * GRID - 1);

    state_t             r_state, w_next;
    logic [COORD_W-1:0] r_x0, r_y0;
    logic [SIZE_W-1:0]  r_n;
    logic [NUM_W-1:0]   r_num;
    logic [K_W-1:0]     r_k, r_wr, r_row, r_col, w_sel_r, w_sel_c;
    logic [CYC_W-1:0]   r_cyc;
    logic [SIZE_W-1:0]  r_off [GRID];
    logic               r_busy, r_done, r_valid;
    point_t             r_pt, w_pt_next;
    logic [IDX_W-1:0]   w_cur_i, w_sel_i;
    logic [SIZE_W-1:0]  w_off_c, w_off_r, w_div_q_tr;
    logic [COORD_W:0]   w_sum_x, w_sum_y;
    logic               w_start, w_enter_emit, w_hs, w_div_load, w_div_busy, w_div_done;
    logic [NUM_W-1:0]   w_div_q;
    logic               w_unused_hi;

    assign w_start      = (r_state == IDLE) && Start;
    assign w_enter_emit = (r_state == CALC) && (r_cyc == c_cyc_last) && (r_k == c_k_last);
    assign w_hs         = (r_state == EMIT) && r_valid && Point_Ready;
    assign w_div_load   = (r_state == CALC) && (r_cyc == '0);
    assign w_div_q_tr   = w_div_q[SIZE_W-1:0];

    serial_const_div #(
        .NUM_W   (NUM_W),
        .DIVISOR (2 * GRID)
    ) u_div (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Load     (w_div_load),
        .Numer    (r_num),
        .Busy     (w_div_busy),
        .Done     (w_div_done),
        .Quotient (w_div_q)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (Start) w_next = CALC;
            CALC:    if (w_enter_emit) w_next = EMIT;
            EMIT:    if (w_hs && r_pt.last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Next point to present; the last offset may still be in flight from the divider.
    always_comb begin
        w_cur_i = r_pt.index[IDX_W-1:0];
        w_sel_r = '0;
        w_sel_c = '0;
        w_sel_i = '0;
        if (r_state == EMIT) begin
            w_sel_i = w_cur_i + IDX_W'(1);
            if (r_col == c_k_last) begin
                w_sel_r = r_row + K_W'(1);
            end else begin
                w_sel_c = r_col + K_W'(1);
                w_sel_r = r_row;
            end
        end
        w_off_c = (w_div_done && (r_wr == w_sel_c)) ? w_div_q_tr : r_off[w_sel_c];
        w_off_r = (w_div_done && (r_wr == w_sel_r)) ? w_div_q_tr : r_off[w_sel_r];
        w_sum_x = {1'b0, r_x0} + (COORD_W+1)'(w_off_c);
        w_sum_y = {1'b0, r_y0} + (COORD_W+1)'(w_off_r);
        w_pt_next       = '0;
        w_pt_next.x     = MAX_COORD_W'(w_sum_x[COORD_W-1:0]);
        w_pt_next.y     = MAX_COORD_W'(w_sum_y[COORD_W-1:0]);
        w_pt_next.index = MAX_IDX_W'(w_sel_i);
        w_pt_next.last  = (w_sel_i == c_idx_last);
        w_pt_next.clip  = w_sum_x[COORD_W] | w_sum_y[COORD_W];
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_x0    <= '0;
            r_y0    <= '0;
            r_n     <= '0;
            r_num   <= '0;
            r_k     <= '0;
            r_wr    <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_cyc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_pt    <= '0;
            for (int i = 0; i < GRID; i++) r_off[i] <= '0;
        end else begin
            if (w_start) begin
                r_x0   <= CubeX_Start;
                r_y0   <= CubeY_Start;
                r_n    <= N;
                r_num  <= NUM_W'(N);
                r_k    <= '0;
                r_cyc  <= '0;
                r_wr   <= '0;
                r_busy <= 1'b1;
                r_done <= 1'b0;
            end
            // Numerator steps N, 3N, 5N ... one step per divider load.
            if (r_state == CALC) begin
                if (r_cyc == '0) r_num <= r_num + NUM_W'({r_n, 1'b0});
                if (r_cyc == c_cyc_last) begin
                    r_cyc <= '0;
                    if (r_k != c_k_last) r_k <= r_k + K_W'(1);
                end else begin
                    r_cyc <= r_cyc + CYC_W'(1);
                end
            end
            if (w_div_done) begin
                r_off[r_wr] <= w_div_q_tr;
                r_wr        <= r_wr + K_W'(1);
            end
            if (w_enter_emit || (w_hs && !r_pt.last)) begin
                r_pt    <= w_pt_next;
                r_row   <= w_sel_r;
                r_col   <= w_sel_c;
                r_valid <= 1'b1;
            end
            if (w_hs && r_pt.last) begin
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
            end
        end
    end

    assign Busy        = r_busy;
    assign Done        = r_done;
    assign Point_Valid = r_valid;
    assign Point_X     = r_pt.x[COORD_W-1:0];
    assign Point_Y     = r_pt.y[COORD_W-1:0];
    assign Point_Index = r_pt.index[IDX_W-1:0];
    assign Point_Last  = r_pt.last;
    assign Point_Clip  = r_pt.clip;

    assign w_unused_hi = ^{r_pt.x >> COORD_W, r_pt.y >> COORD_W, r_pt.index >> IDX_W,
                           w_div_busy, w_div_q >> SIZE_W};

endmodule
`default_nettype wire

// File: tb/tb_grid_center_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_grid_center_gen : GRID=3 and GRID=4 builds vs arithmetic model    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_grid_center_gen;

    logic        Clk = 1'b0;
    logic        Reset_n, st3, st4, Point_Ready, sel;
    logic [10:0] CubeX_Start, CubeY_Start;
    logic [9:0]  N;
    logic        b3, d3, v3, l3, c3, b4, d4, v4, l4, c4;
    logic [10:0] x3, y3, x4, y4;
    logic [3:0]  i3, i4;
    logic        m_busy, m_done, m_valid;
    logic [27:0] m_pt;
    int          checks = 0;
    int          errors = 0;

    always #5 Clk = ~Clk;

    grid_center_gen #(.GRID(3), .COORD_W(11), .SIZE_W(10)) dut3 (
        .Clk(Clk), .Reset_n(Reset_n), .Start(st3), .CubeX_Start(CubeX_Start),
        .CubeY_Start(CubeY_Start), .N(N), .Busy(b3), .Done(d3), .Point_Valid(v3),
        .Point_Ready(Point_Ready), .Point_X(x3), .Point_Y(y3), .Point_Index(i3),
        .Point_Last(l3), .Point_Clip(c3)
    );

    grid_center_gen #(.GRID(4), .COORD_W(11), .SIZE_W(10)) dut4 (
        .Clk(Clk), .Reset_n(Reset_n), .Start(st4), .CubeX_Start(CubeX_Start),
        .CubeY_Start(CubeY_Start), .N(N), .Busy(b4), .Done(d4), .Point_Valid(v4),
        .Point_Ready(Point_Ready), .Point_X(x4), .Point_Y(y4), .Point_Index(i4),
        .Point_Last(l4), .Point_Clip(c4)
    );

    assign m_busy  = sel ? b4 : b3;
    assign m_done  = sel ? d4 : d3;
    assign m_valid = sel ? v4 : v3;
    assign m_pt    = sel ? {x4, y4, i4, l4, c4} : {x3, y3, i3, l3, c3};

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input bit v);
        st3 = v && !sel;
        st4 = v && sel;
    endtask

    task automatic scramble_inputs();
        CubeX_Start = 11'($urandom);
        CubeY_Start = 11'($urandom);
        N           = 10'($urandom);
    endtask

    // mode 0: plain frame, 1: Starts injected while busy, 2: reset mid-EMIT
    task automatic run_frame(input int x0, input int y0, input int n, input int g,
                             input bit rnd, input int mode);
        int off[4];
        int got, cyc, calc, bcyc, calc_len, r, c, ex, ey;
        bit stalled, aborted, rdy;
        logic [27:0] held, exp_pt;
        got = 0; cyc = 0; calc = 0; bcyc = 0;
        stalled = 1'b0; aborted = 1'b0; held = '0;
        calc_len = g * (10 + $clog2(2 * g) + 1);
        for (int k = 0; k < 4; k++) off[k] = ((2 * k + 1) * n) / (2 * g);
        sel = (g == 4);
        CubeX_Start = 11'(x0);
        CubeY_Start = 11'(y0);
        N           = 10'(n);
        set_start(1'b1);
        tick();
        set_start(1'b0);
        scramble_inputs();
        check("busy_on_start", m_busy, 1);
        check("done_clr_on_start", m_done, 0);
        while (got < g * g && cyc < 4000) begin
            set_start(1'b0);
            if (m_busy) bcyc++;
            if (m_busy && !m_valid) calc++;
            if (stalled) check("stall_stable", m_pt, held);
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mode == 1 && (cyc == 10 || cyc == calc_len + 2 ||
                              (m_valid && rdy && got == g * g - 1))) begin
                set_start(1'b1);
                scramble_inputs();
            end
            if (mode == 2 && m_valid && got == 4) begin
                Reset_n = 1'b0;
                tick();
                Reset_n = 1'b1;
                check("reset_mid_emit", {m_busy, m_done, m_valid, m_pt}, 0);
                aborted = 1'b1;
                break;
            end
            stalled = m_valid && !rdy;
            held    = m_pt;
            if (m_valid && rdy) begin
                r  = got / g;
                c  = got % g;
                ex = x0 + off[c];
                ey = y0 + off[r];
                exp_pt = {11'(ex), 11'(ey), 4'(got), got == g * g - 1, (ex > 2047) || (ey > 2047)};
                check($sformatf("g%0d_point%0d", g, got), m_pt, exp_pt);
                got++;
            end
            Point_Ready = rdy;
            tick();
            cyc++;
        end
        set_start(1'b0);
        Point_Ready = 1'b0;
        if (!aborted) begin
            check("frame_complete", got, g * g);
            check("idle_after_frame", {m_busy, m_valid, m_done}, 3'b001);
            if (!rnd) begin
                check("busy_cycles", bcyc, calc_len + g * g);
                check("calc_cycles", calc, calc_len);
            end
        end
    endtask

    initial begin
        Reset_n = 1'b0; st3 = 1'b0; st4 = 1'b0; sel = 1'b0; Point_Ready = 1'b0;
        CubeX_Start = '0; CubeY_Start = '0; N = '0;
        tick();
        tick();
        check("reset_dut3", {b3, d3, v3, x3, y3, i3, l3, c3}, 0);
        check("reset_dut4", {b4, d4, v4, x4, y4, i4, l4, c4}, 0);
        Reset_n = 1'b1;
        tick();
        run_frame(100, 50, 300, 3, 1'b0, 0);
        run_frame(0, 0, 7, 3, 1'b0, 0);
        run_frame(100, 50, 300, 3, 1'b1, 0);
        run_frame(2000, 0, 1000, 3, 1'b0, 0);
        run_frame(100, 50, 300, 3, 1'b0, 1);
        run_frame(100, 50, 300, 3, 1'b1, 2);
        run_frame(1500, 1900, 1023, 3, 1'b1, 0);
        run_frame(0, 0, 400, 4, 1'b0, 0);
        run_frame(30, 40, 0, 4, 1'b1, 0);
        run_frame(77, 9, 0, 3, 1'b0, 0);
        for (int t = 0; t < 4; t++) begin
            run_frame(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                      int'($urandom_range(0, 1023)), (t % 2 == 0) ? 3 : 4, 1'b1, 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
